// File: rtl/cmd_process_arb.sv
// rtl/cmd_process_arb.sv - round-robin upstream command FIFO arbiter driving a completion TX engine
// One command in flight: IDLE grants/reads, LOAD captures the header, ISSUE strobes TX, WAIT awaits done.
module cmd_process_arb #(
  parameter int          NCH       = 2,
  parameter int          TO_CYC    = 1024,
  parameter logic [1:0]  CPL_TYPE  = 2'b01,
  parameter logic [1:0]  CPLD_TYPE = 2'b10
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic [NCH-1:0]     us_cmd_fifo_rd_en_o,
  input  logic [NCH*128-1:0] us_cmd_fifo_dout_i,
  input  logic [NCH-1:0]     us_cmd_fifo_empty,
  output logic               req_compl_o,
  output logic               req_compl_with_data_o,
  input  logic               txe_compl_done_i,
  output logic [2:0]         req_tc_o,
  output logic               req_td_o,
  output logic               req_ep_o,
  output logic [1:0]         req_attr_o,
  output logic [9:0]         req_len_o,
  output logic [15:0]        req_rid_o,
  output logic [7:0]         req_tag_o,
  output logic [7:0]         req_be_o,
  output logic [12:0]        req_addr_o,
  output logic [2:0]         req_ch_o,
  output logic [NCH-1:0]     up_wr_cmd_compl_o,
  output logic               cmd_drop_o,
  output logic               tx_timeout_o,
  output logic               busy_o
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_ISSUE = 2'd2;
  localparam logic [1:0] S_WAIT  = 2'd3;

  localparam int            TW      = $clog2(TO_CYC);
  localparam logic [TW-1:0] TO_LAST = TW'(TO_CYC - 1);

  logic [1:0]     r_state;
  logic [2:0]     r_last;
  logic [1:0]     r_cmd_type;
  logic [TW-1:0]  r_to_cnt;
  logic [2:0]     r_tc;
  logic           r_td;
  logic           r_ep;
  logic [1:0]     r_attr;
  logic [9:0]     r_len;
  logic [15:0]    r_rid;
  logic [7:0]     r_tag;
  logic [7:0]     r_be;
  logic [12:0]    r_addr;
  logic [2:0]     r_ch;
  logic [NCH-1:0] r_compl;
  logic           r_drop;
  logic           r_timeout;

  logic [2:0]     w_grant;
  logic           w_any;
  logic [127:0]   w_slice;
  logic [1:0]     w_type;
  logic           w_type_ok;
  logic [NCH-1:0] w_ch_hot;
  logic           w_unused_bits;

  // Search begins one past the last granted channel; r_last resets to NCH-1 so the first search starts at 0.
  always_comb begin
    w_grant = r_last;
    w_any   = 1'b0;
    for (int i = 0; i < NCH; i++) begin
      for (int c = 0; c < NCH; c++) begin
        if (!w_any && (c == (int'(r_last) + 1 + i) % NCH) && !us_cmd_fifo_empty[c]) begin
          w_any   = 1'b1;
          w_grant = c[2:0];
        end
      end
    end
  end

  always_comb begin
    us_cmd_fifo_rd_en_o = '0;
    for (int c = 0; c < NCH; c++) begin
      us_cmd_fifo_rd_en_o[c] = rst_n && (r_state == S_IDLE) && w_any && (w_grant == c[2:0]);
    end
  end

  // In LOAD r_last holds the channel read in the previous cycle.
  always_comb begin
    w_slice = '0;
    for (int c = 0; c < NCH; c++) begin
      if (r_last == c[2:0]) begin
        w_slice = us_cmd_fifo_dout_i[c*128 +: 128];
      end
    end
  end

  assign w_type        = w_slice[63:62];
  assign w_type_ok     = (w_type == CPL_TYPE) || (w_type == CPLD_TYPE);
  assign w_unused_bits = ^{w_slice[127:64], w_slice[61:55]};

  always_comb begin
    w_ch_hot = '0;
    for (int c = 0; c < NCH; c++) begin
      w_ch_hot[c] = (r_ch == c[2:0]);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_last     <= 3'(NCH - 1);
      r_cmd_type <= 2'b00;
      r_to_cnt   <= '0;
      r_tc       <= '0;
      r_td       <= 1'b0;
      r_ep       <= 1'b0;
      r_attr     <= '0;
      r_len      <= '0;
      r_rid      <= '0;
      r_tag      <= '0;
      r_be       <= '0;
      r_addr     <= '0;
      r_ch       <= '0;
      r_compl    <= '0;
      r_drop     <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_compl   <= '0;
      r_drop    <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_any) begin
            r_last  <= w_grant;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_tc       <= w_slice[54:52];
          r_td       <= w_slice[51];
          r_ep       <= w_slice[50];
          r_attr     <= w_slice[49:48];
          r_len      <= w_slice[47:38];
          r_rid      <= w_slice[37:22];
          r_tag      <= w_slice[21:14];
          r_be       <= w_slice[13:6];
          r_addr     <= {7'b0, w_slice[5:0]};
          r_ch       <= r_last;
          r_cmd_type <= w_type;
          if (w_type_ok) begin
            r_state <= S_ISSUE;
          end else begin
            r_drop  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        S_ISSUE: begin
          r_to_cnt <= '0;
          r_state  <= S_WAIT;
        end
        S_WAIT: begin
          // Done takes priority over a timeout landing in the same cycle.
          if (txe_compl_done_i) begin
            r_compl <= w_ch_hot;
            r_state <= S_IDLE;
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout <= 1'b1;
            r_state   <= S_IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign req_compl_o           = (r_state == S_ISSUE);
  assign req_compl_with_data_o = (r_state == S_ISSUE) && (r_cmd_type == CPLD_TYPE);
  assign req_tc_o              = r_tc;
  assign req_td_o              = r_td;
  assign req_ep_o              = r_ep;
  assign req_attr_o            = r_attr;
  assign req_len_o             = r_len;
  assign req_rid_o             = r_rid;
  assign req_tag_o             = r_tag;
  assign req_be_o              = r_be;
  assign req_addr_o            = r_addr;
  assign req_ch_o              = r_ch;
  assign up_wr_cmd_compl_o     = r_compl;
  assign cmd_drop_o            = r_drop;
  assign tx_timeout_o          = r_timeout;
  assign busy_o                = (r_state != S_IDLE);

endmodule

// File: tb/tb_cmd_process_arb.sv
// tb/tb_cmd_process_arb.sv - directed bench with a transaction-schedule reference model
`timescale 1ns/1ps
module tb_cmd_process_arb;
  localparam int         NCH    = 2;
  localparam int         TO_CYC = 16;
  localparam logic [1:0] CPL    = 2'b01;
  localparam logic [1:0] CPLD   = 2'b10;

  typedef struct packed {
    logic [1:0]  typ;
    logic [2:0]  tc;
    logic        td;
    logic        ep;
    logic [1:0]  attr;
    logic [9:0]  len;
    logic [15:0] rid;
    logic [7:0]  tag;
    logic [7:0]  be;
    logic [5:0]  addr;
  } cmd_t;

  typedef struct {
    string name;
    int    act;
    int    exp;
  } lit_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [NCH-1:0]     rd_en;
  logic [NCH*128-1:0] dout;
  logic [NCH-1:0]     empty;
  logic               req, reqd, done;
  logic [2:0]         tc;
  logic               td, ep;
  logic [1:0]         attr;
  logic [9:0]         len;
  logic [15:0]        rid;
  logic [7:0]         tag, be;
  logic [12:0]        addr;
  logic [2:0]         ch;
  logic [NCH-1:0]     compl;
  logic               drop, tmo, busy;

  cmd_process_arb #(.NCH(NCH), .TO_CYC(TO_CYC), .CPL_TYPE(CPL), .CPLD_TYPE(CPLD)) dut (
    .clk(clk), .rst_n(rst_n),
    .us_cmd_fifo_rd_en_o(rd_en), .us_cmd_fifo_dout_i(dout), .us_cmd_fifo_empty(empty),
    .req_compl_o(req), .req_compl_with_data_o(reqd), .txe_compl_done_i(done),
    .req_tc_o(tc), .req_td_o(td), .req_ep_o(ep), .req_attr_o(attr), .req_len_o(len),
    .req_rid_o(rid), .req_tag_o(tag), .req_be_o(be), .req_addr_o(addr), .req_ch_o(ch),
    .up_wr_cmd_compl_o(compl), .cmd_drop_o(drop), .tx_timeout_o(tmo), .busy_o(busy)
  );

  // Stimulus storage: main only appends; readers keep their own indices.
  logic [127:0] fq [NCH][$];
  cmd_t         mq [NCH][$];
  lit_t         lit_q[$];
  int           epoch = 0;
  int           done_dly = 0;
  logic         force_done = 1'b0;
  logic         resp_done;
  assign done = resp_done | force_done;

  int checks = 0;
  int errors = 0;

  function automatic logic [127:0] mk_cmd(cmd_t f);
    logic [127:0] w;
    w = {64'hA5A5_5A5A_C3C3_3C3C, 64'h0};
    w[63:62] = f.typ;  w[61:55] = 7'h5B;   w[54:52] = f.tc;  w[51] = f.td;
    w[50]    = f.ep;   w[49:48] = f.attr;  w[47:38] = f.len; w[37:22] = f.rid;
    w[21:14] = f.tag;  w[13:6]  = f.be;    w[5:0]   = f.addr;
    return w;
  endfunction

  function automatic logic [64:0] hdr_of(cmd_t f, int c);
    return {f.tc, f.td, f.ep, f.attr, f.len, f.rid, f.tag, f.be, 7'b0, f.addr, 3'(c)};
  endfunction

  // FIFO emulation: a read strobe seen in one cycle presents data and updated empty in the next.
  int f_rd [NCH];
  initial begin
    logic [NCH-1:0] rd_s;
    dout  = '0;
    empty = '1;
    for (int c = 0; c < NCH; c++) f_rd[c] = 0;
    forever begin
      @(negedge clk);
      rd_s = rd_en;
      @(posedge clk);
      #1;
      for (int c = 0; c < NCH; c++) begin
        if (rd_s[c] && f_rd[c] < fq[c].size()) begin
          dout[c*128 +: 128] = fq[c][f_rd[c]];
          f_rd[c]++;
        end
      end
      #1;
      for (int c = 0; c < NCH; c++) empty[c] = (f_rd[c] >= fq[c].size());
    end
  end

  // TX engine responder: done arrives done_dly cycles after the request (0 = never).
  initial begin
    int dcnt;
    dcnt = 0;
    resp_done = 1'b0;
    forever begin
      @(negedge clk);
      if (req) dcnt = done_dly;
      @(posedge clk);
      #1;
      resp_done = 1'b0;
      if (dcnt > 0) begin
        dcnt--;
        if (dcnt == 0) resp_done = 1'b1;
      end
    end
  end

  // Reference model: schedules each command's visible events as absolute cycle numbers.
  int          n = 0;
  int          m_free, m_last, wait_start, compl_ch;
  int          req_at, hdr_at, drop_at, compl_at, to_at;
  bit          m_wait, req_d;
  int          m_rd [NCH];
  logic [64:0] m_hdr, hdr_pend;

  task automatic model_reset();
    m_free = n + 1;  m_last = NCH - 1;  m_wait = 0;  req_d = 0;
    req_at = -1;  hdr_at = -1;  drop_at = -1;  compl_at = -1;  to_at = -1;
    m_hdr = '0;
  endtask

  task automatic model_step(input logic dn, output logic [8:0] ectl, output logic [64:0] ehdr);
    logic [1:0] erd, ecpl;
    logic       ereq, ereqd, edrop, eto, ebusy;
    int         g;
    cmd_t       f;
    erd   = '0;
    ecpl  = (n == compl_at) ? 2'(1 << compl_ch) : 2'b00;
    ereq  = (n == req_at);
    ereqd = ereq && req_d;
    edrop = (n == drop_at);
    eto   = (n == to_at);
    if (n == hdr_at) m_hdr = hdr_pend;
    if (n >= m_free) begin
      ebusy = 1'b0;
      g = -1;
      for (int i = 0; i < NCH; i++)
        if (g < 0 && mq[(m_last + 1 + i) % NCH].size() > m_rd[(m_last + 1 + i) % NCH])
          g = (m_last + 1 + i) % NCH;
      if (g >= 0) begin
        f = mq[g][m_rd[g]];
        m_rd[g]++;
        m_last   = g;
        erd      = 2'(1 << g);
        hdr_pend = hdr_of(f, g);
        hdr_at   = n + 2;
        if (f.typ == CPL || f.typ == CPLD) begin
          req_at = n + 2;  req_d = (f.typ == CPLD);  wait_start = n + 3;
          m_wait = 1;  compl_ch = g;  m_free = 1 << 30;
        end else begin
          drop_at = n + 2;  m_free = n + 2;
        end
      end
    end else begin
      ebusy = 1'b1;
    end
    if (m_wait && n >= wait_start) begin
      if (dn) begin
        compl_at = n + 1;  m_free = n + 1;  m_wait = 0;
      end else if (n - wait_start == TO_CYC - 1) begin
        to_at = n + 1;  m_free = n + 1;  m_wait = 0;
      end
    end
    ectl = {erd, ereq, ereqd, ecpl, edrop, eto, ebusy};
    ehdr = m_hdr;
  endtask

  // Observed-event counters for the hand-computed checks; cleared when main bumps epoch.
  int   seen_epoch = 0;
  int   rd0_cnt, req_cnt, reqd_cnt, cpl_cnt, drop_cnt, to_cnt, to_cyc, cap_tag, cap_len, cap_cpl;
  int   gq[$];
  int   req_cyc[$];
  int   lit_rd = 0;

  initial begin
    for (int c = 0; c < NCH; c++) m_rd[c] = 0;
    model_reset();
  end

  always @(negedge clk) begin
    logic [8:0]  ectl, actl;
    logic [64:0] ehdr, ahdr;
    if (seen_epoch != epoch) begin
      seen_epoch = epoch;
      rd0_cnt = 0; req_cnt = 0; reqd_cnt = 0; cpl_cnt = 0; drop_cnt = 0; to_cnt = 0;
      to_cyc = 0; cap_tag = 0; cap_len = 0; cap_cpl = 0;
      gq.delete();
      req_cyc.delete();
    end
    if (!rst_n) begin
      model_reset();
      ectl = '0;
      ehdr = '0;
    end else begin
      model_step(done, ectl, ehdr);
    end
    actl = {rd_en, req, reqd, compl, drop, tmo, busy};
    ahdr = {tc, td, ep, attr, len, rid, tag, be, addr, ch};
    checks++;
    if (actl !== ectl) begin
      errors++;
      $display("FAIL ctl cycle %0d actual %h required %h", n, actl, ectl);
    end
    checks++;
    if (ahdr !== ehdr) begin
      errors++;
      $display("FAIL hdr cycle %0d actual %h required %h", n, ahdr, ehdr);
    end
    if (rd_en != '0) gq.push_back(rd_en[1] ? 1 : 0);
    rd0_cnt += int'(rd_en[0]);
    if (req) begin
      req_cnt++;  reqd_cnt += int'(reqd);  cap_tag = int'(tag);  cap_len = int'(len);
      req_cyc.push_back(n);
    end
    if (compl != '0) begin cpl_cnt++; cap_cpl = int'(compl); end
    drop_cnt += int'(drop);
    if (tmo) begin to_cnt++; to_cyc = n; end
    while (lit_rd < lit_q.size()) begin
      checks++;
      if (lit_q[lit_rd].act != lit_q[lit_rd].exp) begin
        errors++;
        $display("FAIL %s actual %0d required %0d", lit_q[lit_rd].name, lit_q[lit_rd].act, lit_q[lit_rd].exp);
      end
      lit_rd++;
    end
    n++;
  end

  task automatic cyc(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic lit(input string nm, input int a, input int e);
    lit_t l;
    l.name = nm;  l.act = a;  l.exp = e;
    lit_q.push_back(l);
  endtask

  task automatic push(input int c, input logic [1:0] typ, input logic [9:0] ln, input logic [7:0] tg);
    cmd_t f;
    f.typ = typ;  f.tc = 3'($urandom);  f.td = 1'($urandom);  f.ep = 1'($urandom);
    f.attr = 2'($urandom);  f.len = ln;  f.rid = 16'($urandom);  f.tag = tg;
    f.be = 8'($urandom);  f.addr = 6'($urandom);
    fq[c].push_back(mk_cmd(f));
    mq[c].push_back(f);
  endtask

  initial begin
    cyc(3);
    rst_n = 1'b1;

    // Done strobes while idle must be ignored.
    epoch++;
    force_done = 1'b1;  cyc(3);  force_done = 1'b0;  cyc(3);
    lit("idle_done_cpl", cpl_cnt, 0);

    // Single CPLD on channel 0, done three cycles after the request.
    epoch++;  done_dly = 3;
    push(0, CPLD, 10'd4, 8'h12);
    cyc(20);
    lit("t1_rd0", rd0_cnt, 1);
    lit("t1_req", req_cnt, 1);
    lit("t1_reqd", reqd_cnt, 1);
    lit("t1_tag", cap_tag, 'h12);
    lit("t1_len", cap_len, 4);
    lit("t1_cpl_cnt", cpl_cnt, 1);
    lit("t1_cpl_val", cap_cpl, 1);

    // Reset the round-robin pointer, then three CPLs per channel with immediate done.
    rst_n = 1'b0;  cyc(2);  rst_n = 1'b1;
    epoch++;  done_dly = 1;
    for (int k = 0; k < 3; k++) begin
      push(0, CPL, 10'(k + 1), 8'(k));
      push(1, CPL, 10'(k + 5), 8'(k + 8));
    end
    cyc(40);
    lit("t2_grants", gq.size(), 6);
    for (int i = 0; i < 6; i++)
      if (i < gq.size()) lit($sformatf("t2_grant%0d", i), gq[i], i % 2);
    lit("t2_cpl_cnt", cpl_cnt, 6);
    lit("t2_req_cnt", req_cnt, 6);
    if (req_cyc.size() == 6) lit("t2_period", req_cyc[5] - req_cyc[0], 20);

    // Unsupported cmd_type on channel 1 is dropped; the following command is served.
    epoch++;
    push(1, 2'b11, 10'd7, 8'h77);
    push(1, CPL, 10'd2, 8'h34);
    cyc(30);
    lit("t3_drop", drop_cnt, 1);
    lit("t3_req", req_cnt, 1);
    lit("t3_tag", cap_tag, 'h34);
    lit("t3_cpl_val", cap_cpl, 2);

    // No done: timeout pulse 16 cycles after WAIT entry.
    epoch++;  done_dly = 0;
    push(0, CPLD, 10'd9, 8'h56);
    cyc(30);
    lit("t4_timeout", to_cnt, 1);
    lit("t4_cpl_cnt", cpl_cnt, 0);
    if (req_cyc.size() == 1) lit("t4_to_delay", to_cyc - req_cyc[0], 17);

    // Done on the last WAIT cycle wins over the timeout.
    epoch++;  done_dly = 16;
    push(1, CPL, 10'd3, 8'h9A);
    cyc(30);
    lit("t5_cpl_cnt", cpl_cnt, 1);
    lit("t5_timeout", to_cnt, 0);

    // Reset while waiting abandons the command silently.
    epoch++;  done_dly = 0;
    push(0, CPL, 10'd1, 8'hBC);
    cyc(6);
    rst_n = 1'b0;
    #1;
    lit("t6_rst_busy", int'(busy), 0);
    lit("t6_rst_req", int'(req), 0);
    lit("t6_rst_tag", int'(tag), 0);
    cyc(2);
    rst_n = 1'b1;
    epoch++;
    cyc(25);
    lit("t6_cpl_cnt", cpl_cnt, 0);
    lit("t6_timeout", to_cnt, 0);
    lit("t6_drop", drop_cnt, 0);

    // After reset the first grant goes to channel 0 again.
    epoch++;  done_dly = 1;
    push(1, CPL, 10'd2, 8'h01);
    push(0, CPL, 10'd2, 8'h02);
    cyc(15);
    if (gq.size() > 0) lit("t7_first_grant", gq[0], 0);
    lit("t7_cpl_cnt", cpl_cnt, 2);

    cyc(2);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmd_process_arb.md
CMD_PROCESS_ARB -- requirements
Module: cmd_process_arb

Interface
REQ-001 SHALL have parameter NCH, default 2: number of upstream command FIFOs (1..8).
REQ-002 SHALL have parameter TO_CYC, default 1024: TX-completion timeout in clk cycles (>=2).
REQ-003 SHALL have parameter CPL_TYPE, default 2'b01: cmd_type code for completion without data.
REQ-004 SHALL have parameter CPLD_TYPE, default 2'b10: cmd_type code for completion with data.
REQ-005 SHALL have port clk  in  1  sole clock, all logic on rising edge.
REQ-006 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-007 SHALL have port us_cmd_fifo_rd_en_o  out  NCH  per-channel FIFO read strobe.
REQ-008 SHALL have port us_cmd_fifo_dout_i  in  NCH*128  channel c data at [c*128+127:c*128], valid the cycle after rd_en.
REQ-009 SHALL have port us_cmd_fifo_empty  in  NCH  per-channel empty flag.
REQ-010 SHALL have port req_compl_o  out  1  TX request strobe.
REQ-011 SHALL have port req_compl_with_data_o  out  1  TX request carries data.
REQ-012 SHALL have port txe_compl_done_i  in  1  TX engine finished current request.
REQ-013 SHALL have ports req_tc_o 3, req_td_o 1, req_ep_o 1, req_attr_o 2, req_len_o 10, req_rid_o 16, req_tag_o 8, req_be_o 8, req_addr_o 13  out  completion header fields.
REQ-014 SHALL have port req_ch_o  out  3  channel index of current command.
REQ-015 SHALL have port up_wr_cmd_compl_o  out  NCH  one-cycle per-channel completion pulse.
REQ-016 SHALL have port cmd_drop_o  out  1  one-cycle pulse: unsupported cmd_type discarded.
REQ-017 SHALL have port tx_timeout_o  out  1  one-cycle pulse: TX done not seen within TO_CYC.
REQ-018 SHALL have port busy_o  out  1  high whenever state != IDLE.

Function
REQ-019 SHALL implement states IDLE, LOAD, ISSUE, WAIT; encoding free; illegal state recovers to IDLE.
REQ-020 IDLE: if any empty bit low, SHALL assert rd_en of exactly one granted channel for one cycle, record grant, go LOAD; else stay.
REQ-021 Grant SHALL be round-robin: search starts at (last granted + 1) mod NCH; after reset, search starts at channel 0.
REQ-022 LOAD: SHALL register fields from granted slice: tc=[54:52], td=[51], ep=[50], attr=[49:48], len=[47:38], rid=[37:22], tag=[21:14], be=[13:6], addr={7'b0,[5:0]}; cmd_type=[63:62]; req_ch_o=grant.
REQ-023 LOAD: cmd_type CPL_TYPE or CPLD_TYPE SHALL go ISSUE; any other SHALL pulse cmd_drop_o next cycle and go IDLE with no TX request.
REQ-024 ISSUE: req_compl_o SHALL be high exactly one cycle; req_compl_with_data_o high that cycle iff cmd_type==CPLD_TYPE; header fields already stable; next state WAIT.
REQ-025 Header fields and req_ch_o SHALL hold from LOAD until the next LOAD.
REQ-026 WAIT: timeout counter SHALL clear on entry and increment each cycle; txe_compl_done_i high SHALL go IDLE and pulse up_wr_cmd_compl_o[req_ch_o] the following cycle.
REQ-027 WAIT: counter reaching TO_CYC-1 without done SHALL pulse tx_timeout_o the following cycle, go IDLE, no completion pulse.
REQ-028 Done and timeout in the same cycle: done SHALL win.
REQ-029 txe_compl_done_i outside WAIT SHALL be ignored.
REQ-030 Minimum per-command period SHALL be 4 cycles (IDLE, LOAD, ISSUE, WAIT with done on first WAIT cycle); back-to-back commands SHALL not need extra idle cycles.
REQ-031 rd_en SHALL never be asserted for an empty channel nor outside IDLE.

Reset
REQ-032 rst_n low SHALL asynchronously force state IDLE, RR pointer to start at channel 0, timeout counter 0, all outputs 0.
REQ-033 Reset mid-WAIT SHALL abandon the command with no completion, drop or timeout pulse.

Verification
REQ-034 NCH=2, ch0 one CPLD cmd len=4 tag=0x12, done 3 cycles after req -> rd_en[0] one cycle, req_compl=req_compl_with_data=1 one cycle, tag_o=0x12, len_o=4, up_wr_cmd_compl_o=2'b01 once.
REQ-035 Both channels hold 3 CPL cmds each, done immediate -> grant order 0,1,0,1,0,1, six compl pulses, period 4 cycles.
REQ-036 cmd_type=2'b11 on ch1 -> cmd_drop_o one pulse, no req_compl_o, next cmd served.
REQ-037 TO_CYC=16, done never asserted -> tx_timeout_o pulse 16 cycles after WAIT entry, state IDLE, no compl pulse.
REQ-038 Done arrives on timeout-boundary cycle -> compl pulse, no timeout pulse; rst_n low during WAIT -> all outputs 0 immediately, no pulses after release.
